// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and helpers for Johnson code consumers
//
// Purpose : FSM state encoding for the checker and the successor function
//           of the Johnson index sequence.
// Contents: jc_state_e (HUNT / LOCKED), jc_expected(prev, width).
package johnson_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } jc_state_e;

    // Index that must follow `prev` in a Johnson sequence of `width` bits.
    // The sequence has 2*width entries, and the last one wraps to 0.
    function automatic int unsigned jc_expected(input int unsigned prev,
                                                input int unsigned width);
        if (prev + 1 >= 2 * width) begin
            return 0;
        end
        return prev + 1;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// rtl/johnson_code_decode.sv - combinational Johnson word to index decoder
//
// Purpose : classify a WIDTH-bit word as a legal Johnson code and return
//           its position in the sequence 0..2*WIDTH-1.
// Ports   : code  - word to decode
//           legal - word is one of the 2*WIDTH legal codes
//           index - position of the word (don't-care when legal=0)
module johnson_code_decode #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic             legal,
    output logic [IDXW-1:0]  index
);

    localparam logic [WIDTH-1:0] ONES = '1;

    int k;

    always_comb begin
        k = 0;
        for (int i = 0; i < WIDTH; i++) begin
            k = k + (code[i] ? 1 : 0);
        end

        // LSB clear: first half of the sequence, ones fill in from the MSB.
        // LSB set: second half, ones drain out from the MSB side.
        if (!code[0]) begin
            legal = (code == ~(ONES >> k));
            index = IDXW'(k);
        end else begin
            legal = (code == (ONES >> (WIDTH - k)));
            index = IDXW'(2 * WIDTH - k);
        end
    end

endmodule

// File: rtl/johnson_dec_chk.sv
// rtl/johnson_dec_chk.sv - Johnson bus decoder with sequence checker and lock FSM
//
// Purpose : decode a sampled Johnson bus to a binary index, flag illegal
//           words and out-of-sequence words, track lock, count errors.
// Ports   : clk, rstn             - clock, async active-low reset
//           in_valid, in_code     - sampled Johnson word
//           count, count_valid    - decoded index and its one-cycle strobe
//           illegal, seq_err      - error strobes aligned with count_valid
//           locked                - FSM is in LOCKED
//           err_cnt               - saturating count of error strobes
module johnson_dec_chk
    import johnson_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int IDXW       = $clog2(2 * WIDTH),
    parameter int LOCK_CNT   = 3,
    parameter int ALLOW_HOLD = 0,
    parameter int ERRW       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_code,
    output logic [IDXW-1:0]  count,
    output logic             count_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERRW-1:0]  err_cnt
);

    localparam int RUNW = $clog2(LOCK_CNT + 1);

    logic            code_legal;
    logic [IDXW-1:0] code_index;

    johnson_code_decode #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_decode (
        .code  (in_code),
        .legal (code_legal),
        .index (code_index)
    );

    jc_state_e       state_q, state_d;
    logic [RUNW-1:0] run_q, run_d;
    logic [IDXW-1:0] prev_q, prev_d;
    logic [IDXW-1:0] count_q, count_d;
    logic            count_valid_q, count_valid_d;
    logic            illegal_q, illegal_d;
    logic            seq_err_q, seq_err_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    logic [IDXW-1:0] expected;
    logic            first_word;
    logic            is_succ;
    logic            is_hold;
    logic            good;

    assign expected   = IDXW'(jc_expected(32'(prev_q), WIDTH));
    assign first_word = (run_q == '0);
    assign is_succ    = (code_index == expected);
    // A repeat only counts as a stall once a run is in progress; the first
    // word after HUNT entry is accepted unconditionally anyway.
    assign is_hold    = (ALLOW_HOLD != 0) && !first_word && !is_succ
                        && (code_index == prev_q);
    assign good       = first_word || is_succ || is_hold;

    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        prev_d        = prev_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        illegal_d     = 1'b0;
        seq_err_d     = 1'b0;
        err_cnt_d     = err_cnt_q;

        if (in_valid) begin
            count_valid_d = 1'b1;
            if (!code_legal) begin
                // prev index is deliberately kept across an illegal word
                count_d   = '0;
                illegal_d = 1'b1;
                run_d     = '0;
                state_d   = HUNT;
            end else begin
                count_d = code_index;
                prev_d  = code_index;
                if (good) begin
                    if (!is_hold && run_q != RUNW'(LOCK_CNT)) begin
                        run_d = run_q + RUNW'(1);
                    end
                    if (run_d == RUNW'(LOCK_CNT)) begin
                        state_d = LOCKED;
                    end
                end else begin
                    // the offending word becomes the first of a new run
                    seq_err_d = 1'b1;
                    run_d     = RUNW'(1);
                    state_d   = HUNT;
                end
            end

            if ((illegal_d || seq_err_d) && err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERRW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= HUNT;
            run_q         <= '0;
            prev_q        <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            prev_q        <= prev_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            illegal_q     <= illegal_d;
            seq_err_q     <= seq_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign locked      = (state_q == LOCKED);
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_johnson_dec_chk.sv
// tb/tb_johnson_dec_chk.sv - self-checking bench for johnson_dec_chk
module tb_johnson_dec_chk;

    localparam int W    = 4;
    localparam int N    = 2 * W;
    localparam int LOCK = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic [3:0] in_code;

    logic [2:0] count       [2];
    logic       count_valid [2];
    logic       illegal     [2];
    logic       seq_err     [2];
    logic       locked      [2];
    logic [7:0] err_cnt     [2];

    always #5 clk = ~clk;

    johnson_dec_chk #(.WIDTH(W), .LOCK_CNT(LOCK), .ALLOW_HOLD(0), .ERRW(8)) dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_code(in_code),
        .count(count[0]), .count_valid(count_valid[0]), .illegal(illegal[0]),
        .seq_err(seq_err[0]), .locked(locked[0]), .err_cnt(err_cnt[0])
    );

    johnson_dec_chk #(.WIDTH(W), .LOCK_CNT(LOCK), .ALLOW_HOLD(1), .ERRW(8)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_code(in_code),
        .count(count[1]), .count_valid(count_valid[1]), .illegal(illegal[1]),
        .seq_err(seq_err[1]), .locked(locked[1]), .err_cnt(err_cnt[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Legal code list built by running the generator rule itself.
    logic [3:0] jc [N];

    function automatic int lookup(input logic [3:0] c);
        for (int i = 0; i < N; i++) begin
            if (jc[i] == c) return i;
        end
        return -1;
    endfunction

    // Reference model, one per DUT (index = ALLOW_HOLD setting).
    int m_run [2], m_prev [2], m_err [2], m_cnt [2];
    bit m_lock [2], m_cv [2], m_ill [2], m_seq [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_prev[d] = 0; m_err[d] = 0; m_cnt[d] = 0;
            m_lock[d] = 0; m_cv[d] = 0; m_ill[d] = 0; m_seq[d] = 0;
        end
    endtask

    task automatic model_step(input bit v, input logic [3:0] c);
        for (int d = 0; d < 2; d++) begin
            int idx, expn;
            bit hold, good;
            m_cv[d] = 0; m_ill[d] = 0; m_seq[d] = 0;
            if (v) begin
                idx = lookup(c);
                m_cv[d] = 1;
                if (idx < 0) begin
                    m_cnt[d] = 0; m_ill[d] = 1; m_run[d] = 0; m_lock[d] = 0;
                end else begin
                    expn = (m_prev[d] + 1) % N;
                    hold = (d == 1) && m_run[d] != 0 && idx != expn && idx == m_prev[d];
                    good = m_run[d] == 0 || idx == expn || hold;
                    if (good) begin
                        if (!hold && m_run[d] < LOCK) m_run[d]++;
                        if (m_run[d] == LOCK) m_lock[d] = 1;
                    end else begin
                        m_seq[d] = 1; m_run[d] = 1; m_lock[d] = 0;
                    end
                    m_prev[d] = idx;
                    m_cnt[d]  = idx;
                end
                if ((m_ill[d] || m_seq[d]) && m_err[d] < 255) m_err[d]++;
            end
        end
    endtask

    task automatic compare_model();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("m%0d.count_valid", d), int'(count_valid[d]), int'(m_cv[d]));
            chk($sformatf("m%0d.illegal", d), int'(illegal[d]), int'(m_ill[d]));
            chk($sformatf("m%0d.seq_err", d), int'(seq_err[d]), int'(m_seq[d]));
            chk($sformatf("m%0d.locked", d), int'(locked[d]), int'(m_lock[d]));
            chk($sformatf("m%0d.err_cnt", d), int'(err_cnt[d]), m_err[d]);
            if (m_cv[d]) chk($sformatf("m%0d.count", d), int'(count[d]), m_cnt[d]);
        end
    endtask

    task automatic apply(input bit v, input logic [3:0] c);
        @(negedge clk);
        in_valid = v;
        in_code  = c;
        @(posedge clk);
        #1;
        model_step(v, c);
        compare_model();
    endtask

    typedef struct {
        logic [3:0] code;
        int         cnt;
        bit         ill;
        bit         seq;
        bit         lk;
        int         err;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic [3:0] c, input int cnt, input bit ill,
                       input bit seq, input bit lk, input int err);
        vec_t e;
        e.code = c; e.cnt = cnt; e.ill = ill; e.seq = seq; e.lk = lk; e.err = err;
        tbl.push_back(e);
    endtask

    initial begin
        logic [3:0] g;
        int r;
        logic [3:0] c;

        g = 4'b0000;
        for (int i = 0; i < N; i++) begin
            jc[i] = g;
            g = {~g[0], g[3:1]};
        end

        // Full sequence twice, lock on third strobe, wrap is clean.
        for (int i = 0; i < 16; i++) add(jc[i % N], i % N, 0, 0, i >= 2, 0);
        // Illegal word breaks lock; relock after three good words.
        add(4'b1010, 0, 1, 0, 0, 1);
        add(4'b1111, 4, 0, 0, 0, 1);
        add(4'b0111, 5, 0, 0, 0, 1);
        add(4'b0011, 6, 0, 0, 1, 1);
        // Walk round to 1100 locked, then skip a step.
        add(4'b0001, 7, 0, 0, 1, 1);
        add(4'b0000, 0, 0, 0, 1, 1);
        add(4'b1000, 1, 0, 0, 1, 1);
        add(4'b1100, 2, 0, 0, 1, 1);
        add(4'b1111, 4, 0, 1, 0, 2);
        add(4'b0111, 5, 0, 0, 0, 2);
        add(4'b0011, 6, 0, 0, 1, 2);

        // Reset state.
        rstn = 1'b0; in_valid = 1'b0; in_code = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d.count", d), int'(count[d]), 0);
            chk($sformatf("rst%0d.count_valid", d), int'(count_valid[d]), 0);
            chk($sformatf("rst%0d.illegal", d), int'(illegal[d]), 0);
            chk($sformatf("rst%0d.seq_err", d), int'(seq_err[d]), 0);
            chk($sformatf("rst%0d.locked", d), int'(locked[d]), 0);
            chk($sformatf("rst%0d.err_cnt", d), int'(err_cnt[d]), 0);
        end
        @(negedge clk);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            apply(1'b1, tbl[i].code);
            chk($sformatf("tbl%0d.count", i), int'(count[0]), tbl[i].cnt);
            chk($sformatf("tbl%0d.illegal", i), int'(illegal[0]), int'(tbl[i].ill));
            chk($sformatf("tbl%0d.seq_err", i), int'(seq_err[0]), int'(tbl[i].seq));
            chk($sformatf("tbl%0d.locked", i), int'(locked[0]), int'(tbl[i].lk));
            chk($sformatf("tbl%0d.err_cnt", i), int'(err_cnt[0]), tbl[i].err);
        end

        // Repeated word: error without hold, stall with hold.
        apply(1'b1, 4'b0001);
        apply(1'b1, 4'b0000);
        apply(1'b1, 4'b1000);
        apply(1'b1, 4'b1100);
        apply(1'b1, 4'b1110);
        apply(1'b1, 4'b1110);
        chk("hold0.seq_err", int'(seq_err[0]), 1);
        chk("hold0.locked", int'(locked[0]), 0);
        chk("hold0.err_cnt", int'(err_cnt[0]), 3);
        chk("hold1.seq_err", int'(seq_err[1]), 0);
        chk("hold1.locked", int'(locked[1]), 1);
        chk("hold1.err_cnt", int'(err_cnt[1]), 2);

        // Idle cycle: no strobe, lock held.
        apply(1'b0, 4'b1010);
        chk("idle.count_valid", int'(count_valid[1]), 0);
        chk("idle.illegal", int'(illegal[1]), 0);
        chk("idle.locked", int'(locked[1]), 1);

        // Error counter saturation.
        for (int i = 0; i < 600; i++) apply(1'b1, (i % 2 == 0) ? 4'b1010 : 4'b0000);
        chk("sat0.err_cnt", int'(err_cnt[0]), 255);
        chk("sat1.err_cnt", int'(err_cnt[1]), 255);

        // Relock, then asynchronous reset between clock edges.
        apply(1'b1, 4'b0000);
        apply(1'b1, 4'b1000);
        apply(1'b1, 4'b1100);
        chk("relock.locked", int'(locked[0]), 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 4'b1010;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("arst%0d.err_cnt", d), int'(err_cnt[d]), 0);
            chk($sformatf("arst%0d.locked", d), int'(locked[d]), 0);
            chk($sformatf("arst%0d.count_valid", d), int'(count_valid[d]), 0);
        end
        @(posedge clk);
        #1;
        chk("arst.no_strobe", int'(illegal[0]), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b1;

        // First legal word after reset is good with run=1.
        apply(1'b1, 4'b0111);
        chk("post_rst.seq_err", int'(seq_err[0]), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      c = jc[(m_prev[0] + 1) % N];
            else if (r < 72) c = jc[m_prev[0]];
            else if (r < 85) c = jc[$urandom_range(0, N - 1)];
            else             c = 4'($urandom_range(0, 15));
            apply($urandom_range(0, 3) != 0, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_dec_chk.md
Name: johnson_dec_chk

Overview:
- Receive-side companion to the Johnson ring counter: samples a Johnson-coded bus and decodes it to a binary state index.
- Validates each code word against the legal Johnson code set and against the expected successor of the previous word.
- Runs a HUNT/LOCKED state machine and keeps a saturating error counter.
- Sits downstream of any Johnson counter, either as a decode stage or as a self-check monitor in benches and silicon.

Parameters:
- WIDTH, 4: Johnson register width. Legal code count is 2*WIDTH.
- IDXW, $clog2(2*WIDTH): width of the decoded index.
- LOCK_CNT, 3: consecutive good words required to declare lock.
- ALLOW_HOLD, 0: 1 means a word equal to the previous one is a legal stall, not an error.
- ERRW, 8: width of the error counter.

Ports:
- clk, input, 1: rising-edge clock.
- rstn, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_code is sampled this cycle.
- in_code, input, WIDTH: Johnson-coded word. Generator convention is out <= {~out[0], out[WIDTH-1:1]}, starting at 0.
- count, output, IDXW: decoded index 0..2*WIDTH-1.
- count_valid, output, 1: one-cycle strobe; count, illegal and seq_err are valid.
- illegal, output, 1: strobe; the sampled word is not a legal Johnson code.
- seq_err, output, 1: strobe; the word is legal but is not the expected successor.
- locked, output, 1: level; the FSM is in LOCKED.
- err_cnt, output, ERRW: saturating count of illegal plus seq_err events.

Behaviour:
- Reset (async assert, sync release): count=0, count_valid=0, illegal=0, seq_err=0, locked=0, err_cnt=0, FSM=HUNT, run=0, prev index=0.
- Legality (combinational), with k = popcount(in_code):
  - If in_code[0]==0: legal iff the ones are contiguous from the MSB, i.e. in_code == ~({WIDTH{1'b1}} >> k). Index = k.
  - If in_code[0]==1: legal iff the ones are contiguous from the LSB, i.e. in_code == {WIDTH{1'b1}} >> (WIDTH-k). Index = 2*WIDTH-k.
  - For WIDTH=4: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
- Latency: in_valid at edge N gives count_valid/count/illegal/seq_err at N+1. Strobes last exactly one cycle. If in_valid=0, no strobes fire and all state holds.
- Illegal word: count=0, illegal=1, seq_err=0, run=0, FSM goes to HUNT, prev index is unchanged.
- Legal word, expected next index = (prev+1) mod 2*WIDTH. Wrap from 2*WIDTH-1 to 0 is a normal successor.
  - good = run==0 (first word after HUNT entry or reset), OR index==expected, OR (ALLOW_HOLD and index==prev).
  - A hold word does not increment run.
- FSM HUNT:
  - good: run++ (saturate at LOCK_CNT). When run reaches LOCK_CNT, go to LOCKED; locked rises in the same cycle as the count_valid of that word.
  - Legal but not good: seq_err=1, run=1 (this word restarts the run), stay in HUNT.
- FSM LOCKED:
  - good: stay.
  - Legal but not good: seq_err=1, go to HUNT, run=1, locked=0 in the strobe cycle.
  - Illegal: go to HUNT, locked=0 in the strobe cycle.
- In both states a legal word updates prev index.
- err_cnt: +1 per illegal or seq_err strobe; saturates at all-ones.
- Reset mid-stream clears everything immediately, with no pending strobe. The first legal word afterwards is good with run=1.

Decomposition:
- Package johnson_pkg: FSM state enum (HUNT, LOCKED) and a function jc_expected(prev, WIDTH).
- One sub-module, johnson_code_decode: combinational in_code -> {legal, index}. Reusable by other Johnson consumers.
- FSM, registers and err_cnt live in johnson_dec_chk.

Test Plan:
1. Hold rstn=0 for 2 cycles, in_valid=0 -> all outputs 0, locked=0, err_cnt=0.
2. Release reset, drive in_valid=1 with 0000,1000,1100,... for 16 cycles -> count 0..7,0..7 one cycle later; locked rises on the 3rd strobe (count=2); err_cnt stays 0; 0001 -> 0000 wraps with no error.
3. While locked, drive 1010 -> illegal=1, count=0, locked=0. Then 1111,0111,0011 -> locked again at count=6; err_cnt=1.
4. While locked at 1100, drive 1111 (skip) -> seq_err=1, locked=0, err_cnt+1. Then 0111,0011 -> relock (run 1,2,3).
5. Repeat 1110 twice: ALLOW_HOLD=0 gives seq_err; ALLOW_HOLD=1 gives no error and locked is held.
6. Alternate 1010/0000 for 600 words with ERRW=8 -> err_cnt saturates at 255. Assert rstn=0 mid-sequence -> err_cnt=0 and locked=0 asynchronously.
